enemy_row_march: RTL and testbench

- Sequential, parametrised row mover for the enemy formation; replaces the per-row combinational movers with one registered block.
- Holds the row origin, the march direction FSM, the per-enemy alive mask and the step-rate counter.
- Emits packed positions for all enemies in the row; dead enemies read NONE.
- Sits between the frame-tick generator / collision logic and the enemy renderer.

---
 rtl/enemy_row_march.sv | 143 ++++++++++++++
 tb/tb_enemy_row_march.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_row_march.sv
// Registered mover for one row of the enemy formation.
// Tracks row origin, march FSM, alive mask and step-rate counter.
module enemy_row_march #(
  parameter int ENEMY_COUNT = 8,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int X_START     = 64,
  parameter int Y_START     = 48,
  parameter int X_SPACING   = 32,
  parameter int STEP_X      = 8,
  parameter int STEP_Y      = 16,
  parameter int X_MIN       = 16,
  parameter int X_MAX       = 600,
  parameter int Y_LIMIT     = 400,
  parameter logic [X_W+Y_W-1:0] NONE = '1
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic                             i_Start,
  input  logic                             i_FrameTick,
  input  logic [3:0]                       i_Period,
  input  logic [ENEMY_COUNT-1:0]           i_Kill,
  output logic [ENEMY_COUNT*(X_W+Y_W)-1:0] o_EnemyPosition,
  output logic [ENEMY_COUNT-1:0]           o_AliveMask,
  output logic                             o_Direction,
  output logic                             o_AllDead,
  output logic                             o_Landed
);

  localparam int PW = X_W + Y_W;
  localparam int IW = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;

  typedef enum logic [2:0] {
    IDLE, RIGHT, LEFT, DROP, LANDED, CLEARED
  } state_t;

  typedef logic [X_W:0] xw_t;
  typedef logic [Y_W:0] yw_t;

  state_t                 state, state_n;
  logic [X_W-1:0]         ox, ox_n;
  logic [Y_W-1:0]         oy, oy_n;
  logic                   dir, dir_n;
  logic [3:0]             cnt, cnt_n;
  logic [ENEMY_COUNT-1:0] alive, alive_n;
  logic [IW-1:0]          lo, hi;
  xw_t                    right_x, left_x;
  yw_t                    new_y;
  logic                   right_edge, left_edge, land;

  // Outermost alive enemies bound the row for the edge test.
  always_comb begin
    lo = '0;
    hi = '0;
    for (int k = ENEMY_COUNT - 1; k >= 0; k--)
      if (alive[k]) lo = IW'(k);
    for (int k = 0; k < ENEMY_COUNT; k++)
      if (alive[k]) hi = IW'(k);
  end

  assign right_x = xw_t'(ox) + xw_t'(hi) * xw_t'(X_SPACING)
                 + xw_t'(STEP_X);
  assign left_x  = xw_t'(ox) + xw_t'(lo) * xw_t'(X_SPACING);
  assign right_edge = right_x > xw_t'(X_MAX);
  assign left_edge  = left_x < xw_t'(X_MIN + STEP_X);
  assign new_y = yw_t'(oy) + yw_t'(STEP_Y);
  assign land  = new_y >= yw_t'(Y_LIMIT);

  always_comb begin
    state_n = state;
    ox_n    = ox;
    oy_n    = oy;
    dir_n   = dir;
    cnt_n   = cnt;
    alive_n = alive & ~i_Kill;
    if (i_Start) begin
      state_n = RIGHT;
      ox_n    = X_W'(X_START);
      oy_n    = Y_W'(Y_START);
      dir_n   = 1'b1;
      cnt_n   = '0;
      alive_n = '1;
    end else if (alive == '0 && state != LANDED) begin
      state_n = CLEARED;
    end else begin
      unique case (state)
        RIGHT, LEFT: begin
          if (i_FrameTick) begin
            if (cnt == i_Period) begin
              cnt_n = '0;
              if (state == RIGHT) begin
                if (right_edge) state_n = DROP;
                else ox_n = ox + X_W'(STEP_X);
              end else begin
                if (left_edge) state_n = DROP;
                else ox_n = ox - X_W'(STEP_X);
              end
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end
        end
        DROP: begin
          oy_n  = new_y[Y_W-1:0];
          dir_n = ~dir;
          if (land) state_n = LANDED;
          else if (dir) state_n = LEFT;
          else state_n = RIGHT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= IDLE;
      ox    <= X_W'(X_START);
      oy    <= Y_W'(Y_START);
      dir   <= 1'b1;
      cnt   <= '0;
      alive <= '1;
    end else begin
      state <= state_n;
      ox    <= ox_n;
      oy    <= oy_n;
      dir   <= dir_n;
      cnt   <= cnt_n;
      alive <= alive_n;
    end
  end

  for (genvar k = 0; k < ENEMY_COUNT; k++) begin : g_pos
    assign o_EnemyPosition[k*PW +: PW] = alive[k]
      ? {ox + X_W'(k * X_SPACING), oy} : NONE;
  end

  assign o_AliveMask = alive;
  assign o_Direction = dir;
  assign o_AllDead   = (state == CLEARED);
  assign o_Landed    = (state == LANDED);

endmodule

// File: tb/tb_enemy_row_march.sv
// Directed bench for enemy_row_march: default row plus a
// low Y_LIMIT instance for the landing scenario.
module tb_enemy_row_march;

  logic         clk = 1'b0;
  logic         rst, start, tick;
  logic [3:0]   period;
  logic [7:0]   kill;
  logic [151:0] pos1, pos2;
  logic [7:0]   mask1, mask2;
  logic         dir1, dir2, dead1, dead2, land1, land2;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  enemy_row_march dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start),
    .i_FrameTick(tick), .i_Period(period), .i_Kill(kill),
    .o_EnemyPosition(pos1), .o_AliveMask(mask1),
    .o_Direction(dir1), .o_AllDead(dead1), .o_Landed(land1)
  );

  enemy_row_march #(.Y_LIMIT(80)) dut_low (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start),
    .i_FrameTick(tick), .i_Period(period), .i_Kill(kill),
    .o_EnemyPosition(pos2), .o_AliveMask(mask2),
    .o_Direction(dir2), .o_AllDead(dead2), .o_Landed(land2)
  );

  function automatic logic [18:0] ep(input logic [151:0] v,
                                     input int k);
    return v[k*19 +: 19];
  endfunction

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ep(pos1, 0) !== {10'd64, 9'd48}) begin
      failures++;
      $display("FAIL reset_e0 got=%h exp=%h", ep(pos1, 0),
               {10'd64, 9'd48});
    end
    checks++;
    if (ep(pos1, 7) !== {10'd288, 9'd48}) begin
      failures++;
      $display("FAIL reset_e7 got=%h exp=%h", ep(pos1, 7),
               {10'd288, 9'd48});
    end
    checks++;
    if ({mask1, dir1, dead1, land1} !== {8'hFF, 3'b100}) begin
      failures++;
      $display("FAIL reset_flags got=%h exp=%h",
               {mask1, dir1, dead1, land1}, {8'hFF, 3'b100});
    end
    ticks(10);
    checks++;
    if (ep(pos1, 0) !== {10'd64, 9'd48}) begin
      failures++;
      $display("FAIL idle_hold got=%h exp=%h", ep(pos1, 0),
               {10'd64, 9'd48});
    end
  endtask

  task automatic test_march();
    period = 4'd0;
    do_start();
    ticks(39);
    checks++;
    if (ep(pos1, 0) !== {10'd376, 9'd48}) begin
      failures++;
      $display("FAIL march39 got=%h exp=%h", ep(pos1, 0),
               {10'd376, 9'd48});
    end
    do_tick();
    checks++;
    if ({ep(pos1, 0), dir1} !== {10'd376, 9'd64, 1'b0}) begin
      failures++;
      $display("FAIL drop got=%h exp=%h", {ep(pos1, 0), dir1},
               {10'd376, 9'd64, 1'b0});
    end
    do_tick();
    checks++;
    if (ep(pos1, 0) !== {10'd368, 9'd64}) begin
      failures++;
      $display("FAIL march_left got=%h exp=%h", ep(pos1, 0),
               {10'd368, 9'd64});
    end
  endtask

  task automatic test_period();
    logic [9:0] exp_x [6] = '{64, 64, 72, 72, 72, 80};
    period = 4'd2;
    do_start();
    for (int i = 0; i < 6; i++) begin
      do_tick();
      checks++;
      if (ep(pos1, 0) !== {exp_x[i], 9'd48}) begin
        failures++;
        $display("FAIL period_tick%0d got=%h exp=%h", i + 1,
                 ep(pos1, 0), {exp_x[i], 9'd48});
      end
    end
    period = 4'd0;
  endtask

  task automatic test_dead_edge();
    do_start();
    @(negedge clk) kill = 8'h80;
    @(negedge clk) kill = 8'h00;
    checks++;
    if ({mask1, ep(pos1, 7)} !== {8'h7F, 19'h7FFFF}) begin
      failures++;
      $display("FAIL kill7 got=%h exp=%h", {mask1, ep(pos1, 7)},
               {8'h7F, 19'h7FFFF});
    end
    ticks(43);
    checks++;
    if (ep(pos1, 6) !== {10'd600, 9'd48}) begin
      failures++;
      $display("FAIL edge_e6 got=%h exp=%h", ep(pos1, 6),
               {10'd600, 9'd48});
    end
    checks++;
    if (ep(pos1, 7) !== 19'h7FFFF) begin
      failures++;
      $display("FAIL edge_e7 got=%h exp=7ffff", ep(pos1, 7));
    end
    do_tick();
    checks++;
    if (ep(pos1, 0) !== {10'd408, 9'd64}) begin
      failures++;
      $display("FAIL edge_drop got=%h exp=%h", ep(pos1, 0),
               {10'd408, 9'd64});
    end
  endtask

  task automatic test_landing();
    period = 4'd0;
    do_start();
    ticks(40);
    checks++;
    if ({ep(pos2, 0), land2, dir2} !==
        {10'd376, 9'd64, 2'b00}) begin
      failures++;
      $display("FAIL land_drop1 got=%h exp=%h",
               {ep(pos2, 0), land2, dir2}, {10'd376, 9'd64, 2'b00});
    end
    ticks(46);
    checks++;
    if ({ep(pos2, 0), land2, dir2} !==
        {10'd16, 9'd80, 2'b11}) begin
      failures++;
      $display("FAIL land_drop2 got=%h exp=%h",
               {ep(pos2, 0), land2, dir2}, {10'd16, 9'd80, 2'b11});
    end
    ticks(3);
    checks++;
    if ({ep(pos2, 0), land2} !== {10'd16, 9'd80, 1'b1}) begin
      failures++;
      $display("FAIL land_frozen got=%h exp=%h",
               {ep(pos2, 0), land2}, {10'd16, 9'd80, 1'b1});
    end
  endtask

  task automatic test_clear();
    do_start();
    ticks(2);
    checks++;
    if (ep(pos1, 0) !== {10'd80, 9'd48}) begin
      failures++;
      $display("FAIL clear_pre got=%h exp=%h", ep(pos1, 0),
               {10'd80, 9'd48});
    end
    @(negedge clk) kill = 8'hFF;
    @(negedge clk) kill = 8'h00;
    checks++;
    if ({mask1, pos1} !== {8'h00, {152{1'b1}}}) begin
      failures++;
      $display("FAIL clear_none got=%h exp=all ones", pos1);
    end
    @(negedge clk);
    checks++;
    if (dead1 !== 1'b1) begin
      failures++;
      $display("FAIL clear_alldead got=%b exp=1", dead1);
    end
    do_start();
    checks++;
    if ({mask1, ep(pos1, 0), dead1} !==
        {8'hFF, 10'd64, 9'd48, 1'b0}) begin
      failures++;
      $display("FAIL restart got=%h exp=%h",
               {mask1, ep(pos1, 0), dead1},
               {8'hFF, 10'd64, 9'd48, 1'b0});
    end
    do_tick();
    checks++;
    if (ep(pos1, 0) !== {10'd72, 9'd48}) begin
      failures++;
      $display("FAIL restart_right got=%h exp=%h", ep(pos1, 0),
               {10'd72, 9'd48});
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tick = 1'b0;
    period = 4'd0;
    kill = 8'h00;
    test_reset();
    test_march();
    test_period();
    test_dead_edge();
    test_landing();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
